readout_packetizer: RTL and testbench
=====================================

// Module: readout_packetizer
// PURPOSE
//  Downstream of the readout shift register. Buffers its non-stallable 8-bit sample stream in a FIFO.
//  Frames every PAYLOAD_LEN samples as one packet: SOF, HEADER, PAYLOAD_LEN data bytes, CHECKSUM.
//  Sends packets as a valid/ready byte stream to the packet router on the dedicated output pins.
// PARAMETERS
//  DEPTH        16     FIFO entries; power of 2, >= PAYLOAD_LEN
//  PAYLOAD_LEN  8      data bytes per packet, 1..DEPTH
//  SOF_BYTE     8'hA5  start-of-frame marker byte
//  CHAN_ID      4'h0   channel id, placed in HEADER[7:4]
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous reset, active-high
//  in_data     in   8   sample byte from the shift register
//  in_valid    in   1   in_data is valid this cycle; the source cannot stall
//  out_data    out  8   packet byte to the router
//  out_valid   out  1   out_data is valid
//  out_ready   in   1   router accepts out_data when out_valid is also high
//  out_sof     out  1   high with the SOF byte
//  out_eof     out  1   high with the CHECKSUM byte
//  fifo_level  out  $clog2(DEPTH)+1   current FIFO occupancy
//  drop_cnt    out  8   count of dropped samples; saturates at 255
//  busy        out  1   high when the FSM is not in IDLE
// BEHAVIOUR
//  Reset:
//   - All outputs are 0; FIFO empty; seq = 0; FSM in IDLE.
//   - rst mid-packet abandons the partial packet. out_valid is 0 after that edge. No checksum is emitted.
//  FIFO write:
//   - Occurs when in_valid=1 and level < DEPTH, using the registered level.
//   - If in_valid=1 and level == DEPTH, the byte is dropped and drop_cnt increments (saturating).
//   - This holds even if a read happens in the same cycle.
//   - A simultaneous write and read leaves the level unchanged.
//  Pointers: wrap modulo DEPTH.
//  FSM states: IDLE -> SOF -> HDR -> PAY -> CSUM -> IDLE.
//   - IDLE: moves to SOF at the next edge when level >= PAYLOAD_LEN.
//     Example: edge N writes the PAYLOAD_LEN-th byte; the FSM enters SOF at edge N+1; out_valid=1 after edge N+1.
//   - Each state holds until an out_valid && out_ready handshake, then advances.
//   - PAY pops one FIFO entry per handshake. It leaves after PAYLOAD_LEN handshakes (beat counter).
//   - After CSUM handshake: IDLE. If level >= PAYLOAD_LEN still holds, the next packet starts one cycle later.
//  Bytes per state:
//   - SOF: SOF_BYTE, with out_sof=1.
//   - HDR: {CHAN_ID, seq[3:0]}.
//   - PAY: FIFO head.
//   - CSUM: XOR of HDR and all payload bytes, with out_eof=1.
//  seq: increments on the CSUM handshake; wraps 15 -> 0.
//  Output stability:
//   - out_valid is 1 in every state except IDLE.
//   - out_data, out_sof and out_eof are registered and stay stable while out_valid=1 and out_ready=0.
//   - out_valid never drops without a handshake, except on rst.
//  Write during a packet: writes continue. Payload bytes are always the oldest PAYLOAD_LEN entries.
//  Widths: checksum is an 8-bit XOR. The beat counter is sized for PAYLOAD_LEN. No arithmetic overflow on any path.
// TESTING
//  1. Basic packet:
//     stimulus: rst, then 8 bytes 8'h01..8'h08, out_ready=1.
//     required: A5, 00, 01..08, checksum 08; sof on A5; eof on checksum; busy low afterwards.
//  2. Backpressure:
//     stimulus: same 8 bytes; out_ready toggles 1/0 every cycle.
//     required: identical byte sequence; out_data held during every ready=0 cycle.
//  3. Overflow and saturation:
//     stimulus: out_ready=0; 20 writes into a DEPTH=16 FIFO.
//     required: fifo_level=16, drop_cnt=4.
//     stimulus: continue to 300 total writes.
//     required: drop_cnt=255.
//  4. Sequence wrap:
//     stimulus: 17 back-to-back packets.
//     required: header low nibble runs 0..15, then 0.
//  5. Reset mid-packet:
//     stimulus: assert rst during the PAY state.
//     required: out_valid=0, fifo_level=0, drop_cnt=0 after the edge; the next packet header is 00.
//  6. Full with simultaneous read:
//     stimulus: level=16, in_valid=1, pop in the same cycle.
//     required: byte dropped; level=15; drop_cnt+1.

Source files
------------

// File: rtl/readout_packetizer.sv
// ---------------------------------------------------------------------------
// readout_packetizer
//
// Purpose:
//   Sits downstream of the readout shift register. The shift register emits
//   an 8-bit sample stream that cannot be stalled, so every sample is first
//   captured in a small FIFO. Once PAYLOAD_LEN samples are buffered, a packet
//   is framed and sent to the packet router as a valid/ready byte stream:
//
//     SOF_BYTE | {CHAN_ID, seq[3:0]} | PAYLOAD_LEN data bytes | XOR checksum
//
//   The checksum is the XOR of the header byte and every payload byte. The
//   sequence number advances on each completed packet and wraps 15 -> 0.
//   Samples that arrive while the FIFO is full are dropped and counted.
//
// Ports:
//   clk         in   1        single clock, rising edge
//   rst         in   1        synchronous reset, active-high
//   in_data     in   8        sample byte from the shift register
//   in_valid    in   1        in_data valid this cycle (source cannot stall)
//   out_data    out  8        packet byte to the router (registered)
//   out_valid   out  1        out_data valid; high in every non-IDLE state
//   out_ready   in   1        router accepts out_data when out_valid is high
//   out_sof     out  1        high together with the SOF byte
//   out_eof     out  1        high together with the checksum byte
//   fifo_level  out  LVL_W    current FIFO occupancy (0..DEPTH)
//   drop_cnt    out  8        dropped-sample count, saturates at 255
//   busy        out  1        high whenever the framer is not idle
// ---------------------------------------------------------------------------
module readout_packetizer #(
    parameter int unsigned DEPTH       = 16,     // power of 2, >= PAYLOAD_LEN
    parameter int unsigned PAYLOAD_LEN = 8,      // 1..DEPTH
    parameter logic [7:0]  SOF_BYTE    = 8'hA5,
    parameter logic [3:0]  CHAN_ID     = 4'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sof,
    output logic                     out_eof,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               drop_cnt,
    output logic                     busy
);

    // -----------------------------------------------------------------------
    // Derived sizes and constants
    // -----------------------------------------------------------------------
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam int unsigned BEAT_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_PKT   = LVL_W'(PAYLOAD_LEN);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PAYLOAD_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_HDR,
        ST_PAY,
        ST_CSUM
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [7:0]        mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]  level_q,    level_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    state_e            state_q,    state_d;
    logic [7:0]        data_q,     data_d;
    logic              sof_q,      sof_d;
    logic              eof_q,      eof_d;
    logic [7:0]        csum_q,     csum_d;
    logic [BEAT_W-1:0] beat_q,     beat_d;
    logic [3:0]        seq_q,      seq_d;

    // -----------------------------------------------------------------------
    // FIFO write side
    // The full decision uses the registered level only, so a pop in the same
    // cycle never makes room for an incoming sample.
    // -----------------------------------------------------------------------
    logic             wr_en;
    logic             drop;
    logic             rd_en;
    logic             handshake;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [7:0]       hdr_byte;

    assign wr_en      = in_valid && (level_q < LVL_FULL);
    assign drop       = in_valid && !(level_q < LVL_FULL);

    // Explicit wrap keeps the pointers correct for any DEPTH, not only when
    // the pointer width happens to roll over naturally.
    assign wr_ptr_nxt = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    assign rd_ptr_nxt = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);

    assign handshake  = out_valid && out_ready;
    assign hdr_byte   = {CHAN_ID, seq_q};

    // NOTE: the sample storage has no reset. Occupancy is tracked by level_q,
    // so stale entries are never presented, and leaving the array out of the
    // reset lets it map onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointer / level / drop counter next-state
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_cnt_d = drop_cnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_nxt;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_nxt;
        end

        // Simultaneous write and read leaves the occupancy unchanged.
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Framer FSM, next-state and registered output bytes
    // The output byte for a state is computed on the transition into it, so
    // out_data/out_sof/out_eof come straight from flops and cannot change
    // while the router is stalling.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written below is given its hold value first, so
        // no path through the case statement can infer a latch.
        state_d = state_q;
        data_d  = data_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        csum_d  = csum_q;
        beat_d  = beat_q;
        seq_d   = seq_q;
        rd_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (level_q >= LVL_PKT) begin
                    state_d = ST_SOF;
                    data_d  = SOF_BYTE;
                    sof_d   = 1'b1;
                end
            end

            ST_SOF: begin
                if (handshake) begin
                    state_d = ST_HDR;
                    data_d  = hdr_byte;
                    sof_d   = 1'b0;
                    csum_d  = hdr_byte;
                end
            end

            ST_HDR: begin
                if (handshake) begin
                    state_d = ST_PAY;
                    data_d  = mem_q[rd_ptr_q];
                    beat_d  = '0;
                end
            end

            ST_PAY: begin
                if (handshake) begin
                    rd_en  = 1'b1;
                    csum_d = csum_q ^ data_q;
                    if (beat_q == BEAT_LAST) begin
                        state_d = ST_CSUM;
                        data_d  = csum_q ^ data_q;
                        eof_d   = 1'b1;
                    end else begin
                        // Look ahead one entry: the next payload byte is
                        // already buffered because the packet only started
                        // once PAYLOAD_LEN samples were present.
                        beat_d = beat_q + BEAT_W'(1);
                        data_d = mem_q[rd_ptr_nxt];
                    end
                end
            end

            ST_CSUM: begin
                if (handshake) begin
                    state_d = ST_IDLE;
                    data_d  = 8'h00;
                    eof_d   = 1'b0;
                    seq_d   = seq_q + 4'd1;  // 4-bit, wraps 15 -> 0
                end
            end

            default: begin
                state_d = ST_IDLE;
                data_d  = 8'h00;
                sof_d   = 1'b0;
                eof_d   = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers with synchronous reset
    // A reset mid-packet simply drops the framer back to IDLE with an empty
    // FIFO; the partial packet is abandoned without a checksum.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= 8'h00;
            state_q    <= ST_IDLE;
            data_q     <= 8'h00;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            csum_q     <= 8'h00;
            beat_q     <= '0;
            seq_q      <= 4'h0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
            data_q     <= data_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            csum_q     <= csum_d;
            beat_q     <= beat_d;
            seq_q      <= seq_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out_valid  = (state_q != ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_data   = data_q;
    assign out_sof    = sof_q;
    assign out_eof    = eof_q;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_readout_packetizer.sv
// ---------------------------------------------------------------------------
// tb_readout_packetizer
//
// Self-checking bench for readout_packetizer. Inputs are driven one cycle at
// a time through tick(); at the falling edge tick() compares the DUT against
// a queue-based reference model (FIFO as a queue, each packet built as a byte
// array when it starts) and then advances the model by the effect of the
// coming rising edge. Scenario tasks add their own targeted comparisons.
// ---------------------------------------------------------------------------
module tb_readout_packetizer;

    localparam int         DEPTH = 16;
    localparam int         PL    = 8;
    localparam logic [7:0] SOF   = 8'hA5;
    localparam logic [3:0] CHAN  = 4'h0;
    localparam int         PKT   = PL + 3;   // SOF + HDR + payload + CSUM

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic       out_eof;
    logic [4:0] fifo_level;
    logic [7:0] drop_cnt;
    logic       busy;

    always #5 clk = ~clk;

    readout_packetizer #(
        .DEPTH       (DEPTH),
        .PAYLOAD_LEN (PL),
        .SOF_BYTE    (SOF),
        .CHAN_ID     (CHAN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_fifo [$];
    logic [7:0] m_pkt  [PKT];
    int         m_drops  = 0;
    int         m_seq    = 0;
    int         m_pos    = 0;
    bit         m_active = 1'b0;
    bit         m_ok     = 1'b0;

    // Every accepted output byte, in order
    logic [7:0] obs_data [$];
    bit         obs_sof  [$];
    bit         obs_eof  [$];

    // Stall tracking for the output-stability check
    bit         stall_q = 1'b0;
    logic [7:0] held_data;
    logic       held_sof;
    logic       held_eof;
    bit         rdy_phase = 1'b1;

    // -----------------------------------------------------------------------
    // One clock cycle: drive, compare at negedge, advance model, pass posedge
    // -----------------------------------------------------------------------
    task automatic tick(input bit r, input bit v, input logic [7:0] d, input bit rdy);
        int         lvl;
        bit         hs;
        logic [7:0] x;
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);

        if (stall_q) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held_data ||
                out_sof !== held_sof || out_eof !== held_eof) begin
                n_errors++;
                $display("FAIL hold: valid=%b data=%h sof=%b eof=%b, required valid=1 data=%h sof=%b eof=%b",
                         out_valid, out_data, out_sof, out_eof, held_data, held_sof, held_eof);
            end
        end
        stall_q   = !r && (out_valid === 1'b1) && !rdy;
        held_data = out_data;
        held_sof  = out_sof;
        held_eof  = out_eof;

        if (m_ok) begin
            n_checks++;
            if (out_valid !== m_active || busy !== m_active) begin
                n_errors++;
                $display("FAIL model_valid: valid=%b busy=%b, required %b", out_valid, busy, m_active);
            end
            n_checks++;
            if (fifo_level !== 5'(m_fifo.size())) begin
                n_errors++;
                $display("FAIL model_level: got %0d, required %0d", fifo_level, m_fifo.size());
            end
            n_checks++;
            if (drop_cnt !== 8'(m_drops)) begin
                n_errors++;
                $display("FAIL model_drops: got %0d, required %0d", drop_cnt, m_drops);
            end
            if (m_active) begin
                n_checks++;
                if (out_data !== m_pkt[m_pos] || out_sof !== (m_pos == 0) || out_eof !== (m_pos == PKT - 1)) begin
                    n_errors++;
                    $display("FAIL model_byte[%0d]: data=%h sof=%b eof=%b, required data=%h sof=%b eof=%b",
                             m_pos, out_data, out_sof, out_eof, m_pkt[m_pos], (m_pos == 0), (m_pos == PKT - 1));
                end
            end
        end

        if (!r && out_valid === 1'b1 && rdy) begin
            obs_data.push_back(out_data);
            obs_sof.push_back(out_sof);
            obs_eof.push_back(out_eof);
        end

        // Advance the model by the coming rising edge
        if (r) begin
            m_fifo.delete();
            m_drops  = 0;
            m_seq    = 0;
            m_pos    = 0;
            m_active = 1'b0;
            m_ok     = 1'b1;
        end else if (m_ok) begin
            lvl = m_fifo.size();
            hs  = m_active && rdy;
            if (hs && m_pos >= 2 && m_pos <= PL + 1) void'(m_fifo.pop_front());
            if (v) begin
                if (lvl < DEPTH) m_fifo.push_back(d);
                else if (m_drops < 255) m_drops++;
            end
            if (m_active) begin
                if (hs) begin
                    if (m_pos == PKT - 1) begin
                        m_active = 1'b0;
                        m_seq    = (m_seq + 1) % 16;
                    end else begin
                        m_pos++;
                    end
                end
            end else if (lvl >= PL) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_pkt[0] = SOF;
                m_pkt[1] = {CHAN, 4'(m_seq)};
                x        = m_pkt[1];
                for (int i = 0; i < PL; i++) begin
                    m_pkt[2 + i] = m_fifo[i];
                    x            = x ^ m_fifo[i];
                end
                m_pkt[PKT - 1] = x;
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        obs_data.delete();
        obs_sof.delete();
        obs_eof.delete();
    endtask

    // Idle the input until n bytes have been accepted in total (bounded)
    task automatic drain(input int n, input bit toggle, input int budget, input string tag);
        int c;
        c = 0;
        while (obs_data.size() < n && c < budget) begin
            tick(1'b0, 1'b0, 8'h00, toggle ? rdy_phase : 1'b1);
            if (toggle) rdy_phase = !rdy_phase;
            c++;
        end
        n_checks++;
        if (obs_data.size() < n) begin
            n_errors++;
            $display("FAIL %s_timeout: got %0d bytes, required %0d", tag, obs_data.size(), n);
        end
    endtask

    // Expected stream for payload 01..08 with seq 0
    function automatic logic [7:0] basic_byte(input int i);
        logic [7:0] x;
        if (i == 0) return SOF;
        if (i == 1) return {CHAN, 4'h0};
        if (i <= PL + 1) return 8'(i - 1);
        x = {CHAN, 4'h0};
        for (int k = 1; k <= PL; k++) x = x ^ 8'(k);
        return x;
    endfunction

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        n_checks++;
        if (out_data !== 8'h00 || out_sof !== 1'b0 || out_eof !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_data: data=%h sof=%b eof=%b, required 00 0 0", out_data, out_sof, out_eof);
        end
        n_checks++;
        if (fifo_level !== 5'd0 || drop_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_counts: level=%0d drops=%0d, required 0 0", fifo_level, drop_cnt);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 1; i <= PL; i++) tick(1'b0, 1'b1, 8'(i), 1'b1);
        drain(PKT, 1'b0, 100, "basic");
        for (int i = 0; i < PKT; i++) begin
            n_checks++;
            if (obs_data[i] !== basic_byte(i) || obs_sof[i] !== (i == 0) || obs_eof[i] !== (i == PKT - 1)) begin
                n_errors++;
                $display("FAIL basic_byte[%0d]: data=%h sof=%b eof=%b, required data=%h sof=%b eof=%b",
                         i, obs_data[i], obs_sof[i], obs_eof[i], basic_byte(i), (i == 0), (i == PKT - 1));
            end
        end
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_idle: busy=%b valid=%b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rdy_phase = 1'b1;
        for (int i = 1; i <= PL; i++) begin
            tick(1'b0, 1'b1, 8'(i), rdy_phase);
            rdy_phase = !rdy_phase;
        end
        drain(PKT, 1'b1, 200, "bp");
        for (int i = 0; i < PKT; i++) begin
            n_checks++;
            if (obs_data[i] !== basic_byte(i)) begin
                n_errors++;
                $display("FAIL bp_byte[%0d]: got %h, required %h", i, obs_data[i], basic_byte(i));
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b0);
        n_checks++;
        if (fifo_level !== 5'd16 || drop_cnt !== 8'd4) begin
            n_errors++;
            $display("FAIL ovf_20: level=%0d drops=%0d, required 16 4", fifo_level, drop_cnt);
        end
        for (int i = 20; i < 300; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b0);
        n_checks++;
        if (drop_cnt !== 8'd255 || fifo_level !== 5'd16) begin
            n_errors++;
            $display("FAIL ovf_sat: level=%0d drops=%0d, required 16 255", fifo_level, drop_cnt);
        end
    endtask

    task automatic test_full_read();
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b1);   // SOF accepted
        tick(1'b0, 1'b0, 8'h00, 1'b1);   // HDR accepted, now in payload
        n_checks++;
        if (fifo_level !== 5'd16 || drop_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL full_pre: level=%0d drops=%0d, required 16 0", fifo_level, drop_cnt);
        end
        tick(1'b0, 1'b1, 8'h5C, 1'b1);   // pop and a write while full
        n_checks++;
        if (fifo_level !== 5'd15 || drop_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL full_rw: level=%0d drops=%0d, required 15 1", fifo_level, drop_cnt);
        end
        drain(2 * PKT, 1'b0, 100, "full");
    endtask

    task automatic test_seq_wrap();
        int c;
        do_reset();
        c = 0;
        while (obs_data.size() < 17 * PKT && c < 4000) begin
            tick(1'b0, ($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 85));
            c++;
        end
        n_checks++;
        if (obs_data.size() < 17 * PKT) begin
            n_errors++;
            $display("FAIL seq_timeout: got %0d bytes, required %0d", obs_data.size(), 17 * PKT);
        end
        for (int k = 0; k < 17; k++) begin
            n_checks++;
            if (obs_sof[k * PKT] !== 1'b1 || obs_data[k * PKT + 1] !== {CHAN, 4'(k % 16)}) begin
                n_errors++;
                $display("FAIL seq_hdr[%0d]: sof=%b hdr=%h, required sof=1 hdr=%h",
                         k, obs_sof[k * PKT], obs_data[k * PKT + 1], {CHAN, 4'(k % 16)});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 18; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b0);
        drain(4, 1'b0, 50, "mid");       // SOF, HDR and two payload bytes
        tick(1'b1, 1'b1, 8'hEE, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== 5'd0 || drop_cnt !== 8'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: valid=%b level=%0d drops=%0d busy=%b, required 0 0 0 0",
                     out_valid, fifo_level, drop_cnt, busy);
        end
        obs_data.delete();
        obs_sof.delete();
        obs_eof.delete();
        for (int i = 0; i < PL; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b1);
        drain(PKT, 1'b0, 100, "mid_next");
        n_checks++;
        if (obs_data[0] !== SOF || obs_sof[0] !== 1'b1 || obs_data[1] !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_next: sof_byte=%h sof=%b hdr=%h, required %h 1 00",
                     obs_data[0], obs_sof[0], obs_data[1], SOF);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            tick(1'b0, ($urandom_range(0, 99) < 70), 8'($urandom), ($urandom_range(0, 99) < 50));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_full_read();
        test_seq_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
